palindrome_stream_gen: RTL

//   Transmit-side companion of the palindrome tester. Generates a byte string of a

---
 rtl/palindrome_stream_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/palindrome_stream_gen.sv
// ============================================================================
// Module      : palindrome_stream_gen
// Description : Streams an LFSR-built palindrome (optionally corrupted) into the
//               palindrome tester and checks the tester's verdict.
//               Optional packet statistics: PALGEN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palindrome_stream_gen #(
  parameter int         MAX_DATA = 128,
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int         TIMEOUT  = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(MAX_DATA)-1:0] length,
  input  logic                        corrupt,
  output logic [7:0]                  dataOut,
  output logic                        dataVld,
  input  logic                        ready,
  input  logic                        isTrue,
  input  logic                        outVld,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic                        err,
  output logic [15:0]                 passCnt,
  output logic [15:0]                 failCnt
);

  localparam int         LW          = $clog2(MAX_DATA);
  localparam int         AW          = $clog2(MAX_DATA / 2);
  localparam int         TW          = $clog2(TIMEOUT + 1);
  localparam logic [7:0] C_LFSR_MASK = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_SEND_A   = 3'd2,
    S_SEND_B   = 3'd3,
    S_GAP      = 3'd4,
    S_WAIT_RES = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic          r_corrupt;
  logic [7:0]    r_lfsr;
  logic [7:0]    r_buf [MAX_DATA/2];
  logic [TW-1:0] r_waitCnt;
  logic [7:0]    r_dataOut;
  logic          r_dataVld;
  logic          r_pass;
  logic          r_timeout;
  logic          r_err;

  logic [LW-1:0] w_half;
  logic [LW-1:0] w_floor;
  logic          w_accept;
  logic          w_reject;
  logic          w_emitA;
  logic          w_emitB;
  logic          w_capture;
  logic          w_expire;
  logic          w_expected;
  logic [7:0]    w_mirrorByte;

  assign w_floor      = r_len >> 1;
  assign w_half       = w_floor + {{(LW-1){1'b0}}, r_len[0]};
  assign w_expected   = (r_len < LW'(2)) | ~r_corrupt;
  // Only the last mirrored byte (buffer[0]) carries the corruption.
  assign w_mirrorByte = r_buf[r_idx[AW-1:0]] ^ {7'b0, r_corrupt && (r_idx == '0)};

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_emitA     = 1'b0;
    w_emitB     = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    done        = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start && (length != '0)) begin
          w_accept    = 1'b1;
          w_stateNext = S_WAIT_RDY;
        end else if (start) begin
          w_reject = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (ready) begin
          w_emitA = 1'b1;
          if (w_half == LW'(1)) w_stateNext = (r_len == LW'(1)) ? S_GAP : S_SEND_B;
          else                  w_stateNext = S_SEND_A;
        end
      end
      S_SEND_A: begin
        w_emitA = 1'b1;
        if (r_idx == w_half - LW'(1)) w_stateNext = S_SEND_B;
      end
      S_SEND_B: begin
        w_emitB = 1'b1;
        if (r_idx == '0) w_stateNext = S_GAP;
      end
      S_GAP: w_stateNext = S_WAIT_RES;
      S_WAIT_RES: begin
        if (outVld) begin
          w_capture   = 1'b1;
          w_stateNext = S_DONE;
        end else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
          w_expire    = 1'b1;
          w_stateNext = S_DONE;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_corrupt <= 1'b0;
      r_lfsr    <= SEED;
      r_waitCnt <= '0;
      r_dataOut <= 8'h00;
      r_dataVld <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err     <= w_reject;
      r_dataVld <= w_emitA | w_emitB;
      r_waitCnt <= (r_state == S_WAIT_RES) ? r_waitCnt + TW'(1) : '0;
      if (w_accept) begin
        r_len     <= length;
        r_corrupt <= corrupt;
        r_idx     <= '0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_emitA) begin
        r_dataOut <= r_lfsr;
        r_lfsr    <= (r_lfsr >> 1) ^ (r_lfsr[0] ? C_LFSR_MASK : 8'h00);
        // Switching to the mirror half: point at buffer[floor(L/2)-1].
        if (w_stateNext == S_SEND_B) r_idx <= w_floor - LW'(1);
        else                         r_idx <= r_idx + LW'(1);
      end
      if (w_emitB) begin
        r_dataOut <= w_mirrorByte;
        r_idx     <= r_idx - LW'(1);
      end
      if (w_capture) begin
        r_pass    <= (isTrue == w_expected);
        r_timeout <= 1'b0;
      end
      if (w_expire) begin
        r_pass    <= 1'b0;
        r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_emitA) r_buf[r_idx[AW-1:0]] <= r_lfsr;
  end

  assign dataOut = r_dataOut;
  assign dataVld = r_dataVld;
  assign pass    = r_pass;
  assign timeout = r_timeout;
  assign err     = r_err;

`ifdef PALGEN_STATS_EN
  logic [15:0] r_passCnt;
  logic [15:0] r_failCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_passCnt <= 16'h0000;
      r_failCnt <= 16'h0000;
    end else if (r_state == S_DONE) begin
      if (r_pass && (r_passCnt != 16'hFFFF))  r_passCnt <= r_passCnt + 16'd1;
      if (!r_pass && (r_failCnt != 16'hFFFF)) r_failCnt <= r_failCnt + 16'd1;
    end
  end

  assign passCnt = r_passCnt;
  assign failCnt = r_failCnt;
`else
  assign passCnt = 16'h0000;
  assign failCnt = 16'h0000;
`endif

endmodule

`default_nettype wire
